ind_seq_checker: RTL and testbench

- Monitors the 3-bit indicator code stream produced by the indicator sequencer, which emits 0, 4, 1, 3, 6, 2, 7, 5 and then repeats.
- Acquires phase lock on that stream, flags each out-of-order code and keeps a saturating error count.
- Sits directly downstream of the sequencer and in parallel with the indicator outputs; it provides self-check and status for the display path.

---
 rtl/ind_pkg.sv | 18 +
 rtl/ind_seq_rom.sv | 23 ++
 rtl/ind_seq_checker.sv | 125 ++++++++++++
 tb/tb_ind_seq_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ind_pkg.sv
// Shared definitions for the indicator sequencer and its checker: code width,
// the 8-step sequence table and the checker state encoding.
package ind_pkg;

    localparam int IND_W = 3;

    // Entry i is the code emitted at step i: 0,4,1,3,6,2,7,5.
    localparam logic [7:0][IND_W-1:0] SEQ = {
        3'd5, 3'd7, 3'd2, 3'd6, 3'd3, 3'd1, 3'd4, 3'd0
    };

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } ind_state_e;

endpackage

// File: rtl/ind_seq_rom.sv
// Combinational lookup on the indicator sequence: step index to code, and the
// inverse (code to step index), which always exists because the table is a permutation.
module ind_seq_rom
    import ind_pkg::*;
(
    input  logic [IND_W-1:0] idx,
    input  logic [IND_W-1:0] code,
    output logic [IND_W-1:0] idx_code,
    output logic [IND_W-1:0] code_idx
);

    assign idx_code = SEQ[idx];

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        code_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (SEQ[i] == code) code_idx = IND_W'(i);
        end
    end

endmodule

// File: rtl/ind_seq_checker.sv
// Phase-locks onto the indicator code stream, flags out-of-order codes while
// locked and keeps a saturating error count. Define IND_CHK_ERR_CLR_EN to add err_clr.
module ind_seq_checker
    import ind_pkg::*;
#(
    parameter int LOCK_CNT  = 3,
    parameter int LOSS_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IND_W-1:0]     in_code,
`ifdef IND_CHK_ERR_CLR_EN
    input  logic                 err_clr,
`endif
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [IND_W-1:0]     exp_code
);

    localparam logic [1:0] ST_HUNT   = HUNT;
    localparam logic [1:0] ST_ACQ    = ACQ;
    localparam logic [1:0] ST_LOCKED = LOCKED;

    localparam logic [2:0]           LOCK_LIM = 3'(LOCK_CNT);
    localparam logic [2:0]           LOSS_LIM = 3'(LOSS_CNT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    logic [1:0]           state, state_nx;
    logic [IND_W-1:0]     exp_idx, exp_idx_nx;
    logic [2:0]           match_cnt, match_nx;
    logic [2:0]           miss_cnt, miss_nx;
    logic                 err_hit;
    logic [ERR_CNT_W-1:0] err_cnt_nx;
    logic [IND_W-1:0]     nx_code;
    logic [IND_W-1:0]     in_idx;
    logic                 hit;

    ind_seq_rom u_rom (
        .idx      (exp_idx_nx),
        .code     (in_code),
        .idx_code (nx_code),
        .code_idx (in_idx)
    );

    // exp_code already holds SEQ[exp_idx] whenever the comparison matters.
    assign hit = (in_code == exp_code);

    always_comb begin
        state_nx   = state;
        exp_idx_nx = exp_idx;
        match_nx   = match_cnt;
        miss_nx    = miss_cnt;
        err_hit    = 1'b0;
        if (in_valid) begin
            case (state)
                ST_HUNT: begin
                    exp_idx_nx = in_idx + 3'd1;
                    match_nx   = 3'd1;
                    state_nx   = ST_ACQ;
                end
                ST_ACQ: begin
                    if (hit) begin
                        exp_idx_nx = exp_idx + 3'd1;
                        match_nx   = match_cnt + 3'd1;
                        if (match_cnt + 3'd1 == LOCK_LIM) begin
                            state_nx = ST_LOCKED;
                            miss_nx  = 3'd0;
                        end
                    end else begin
                        exp_idx_nx = in_idx + 3'd1;
                        match_nx   = 3'd1;
                    end
                end
                ST_LOCKED: begin
                    exp_idx_nx = exp_idx + 3'd1;
                    if (hit) begin
                        miss_nx = 3'd0;
                    end else begin
                        err_hit = 1'b1;
                        miss_nx = miss_cnt + 3'd1;
                        if (miss_cnt + 3'd1 == LOSS_LIM) state_nx = ST_HUNT;
                    end
                end
                default: state_nx = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        err_cnt_nx = err_cnt;
        if (err_hit && err_cnt != ERR_MAX) err_cnt_nx = err_cnt + 1'b1;
`ifdef IND_CHK_ERR_CLR_EN
        // A clear coinciding with a locked mismatch still records that mismatch.
        if (err_clr) err_cnt_nx = err_hit ? ERR_CNT_W'(1) : '0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HUNT;
            exp_idx   <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            exp_code  <= '0;
        end else begin
            state     <= state_nx;
            exp_idx   <= exp_idx_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
            locked    <= (state_nx == ST_LOCKED);
            err_pulse <= err_hit;
            err_cnt   <= err_cnt_nx;
            exp_code  <= (state_nx == ST_HUNT) ? '0 : nx_code;
        end
    end

endmodule

// File: tb/tb_ind_seq_checker.sv
// Self-checking bench for ind_seq_checker: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural model of the stream rules.
module tb_ind_seq_checker;

    localparam int LOCK_CNT  = 3;
    localparam int LOSS_CNT  = 2;
    localparam int ERR_CNT_W = 8;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic [2:0]           in_code = 3'd0;
    logic                 err_clr = 1'b0;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [2:0]           exp_code;

    int checks = 0;
    int errors = 0;

    int seq_tab [8] = '{0, 4, 1, 3, 6, 2, 7, 5};

    // Model: m_run counts coherent samples while unlocked (0 = no reference yet),
    // m_pos is the step index expected next.
    bit m_locked;
    bit m_pulse;
    int m_pos;
    int m_run;
    int m_miss;
    int m_err;

    ind_seq_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_CNT  (LOSS_CNT),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_code   (in_code),
`ifdef IND_CHK_ERR_CLR_EN
        .err_clr   (err_clr),
`endif
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .exp_code  (exp_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int pos_of(input int code);
        for (int i = 0; i < 8; i++) if (seq_tab[i] == code) return i;
        return 0;
    endfunction

    function automatic int wrong_code();
        return (seq_tab[m_pos] + 1 + $urandom_range(0, 6)) % 8;
    endfunction

    function automatic int good_code();
        return seq_tab[m_pos];
    endfunction

    task automatic model_step(input bit r, input bit v, input int c, input bit clr);
        m_pulse = 0;
        if (r) begin
            m_locked = 0; m_pos = 0; m_run = 0; m_miss = 0; m_err = 0;
            return;
        end
        if (v) begin
            if (!m_locked) begin
                if (m_run == 0 || c != seq_tab[m_pos]) begin
                    m_pos = (pos_of(c) + 1) % 8;
                    m_run = 1;
                end else begin
                    m_pos = (m_pos + 1) % 8;
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_locked = 1;
                        m_miss   = 0;
                    end
                end
            end else begin
                m_pos = (m_pos + 1) % 8;
                if (c == seq_tab[(m_pos + 7) % 8]) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    if (m_err < ERR_MAX) m_err++;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_locked = 0;
                        m_run    = 0;
                    end
                end
            end
        end
`ifdef IND_CHK_ERR_CLR_EN
        if (clr) m_err = m_pulse ? 1 : 0;
`endif
    endtask

    task automatic tick(input bit r, input bit v, input int c, input bit clr);
        rst = r; in_valid = v; in_code = 3'(c); err_clr = clr;
        @(posedge clk);
        model_step(r, v, c, clr);
        #1;
        check("locked",    int'(locked),    int'(m_locked));
        check("err_pulse", int'(err_pulse), int'(m_pulse));
        check("err_cnt",   int'(err_cnt),   m_err);
        check("exp_code",  int'(exp_code),  (m_locked || m_run > 0) ? seq_tab[m_pos] : 0);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) tick(0, 1, good_code(), 0);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0);
        tick(1, 1, $urandom_range(0, 7), 0);
    endtask

    initial begin
        // Reset state.
        do_reset();

        // Clean stream from code 0: lock rises in the third cycle after the first sample.
        tick(0, 1, 0, 0);
        tick(0, 1, 4, 0);
        check("not_locked_yet", int'(locked), 0);
        tick(0, 1, 1, 0);
        check("locked_cycle3", int'(locked), 1);
        clean(9);

        // Single substitution of 7 for 6 while locked.
        while (good_code() != 6) clean(1);
        tick(0, 1, 7, 0);
        check("single_err_cnt", int'(err_cnt), 1);
        check("single_keeps_lock", int'(locked), 1);
        tick(0, 1, 2, 0);
        check("next_code_matches", int'(err_pulse), 0);
        clean(4);

        // Two consecutive wrong codes drop lock, then relock after three clean samples.
        tick(0, 1, wrong_code(), 0);
        tick(0, 1, wrong_code(), 0);
        check("double_err_cnt", int'(err_cnt), 3);
        check("lost_lock", int'(locked), 0);
        clean(3);
        check("relocked", int'(locked), 1);

        // Mid-sequence start at 6 with in_valid toggling.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) tick(0, 1, seq_tab[(4 + i / 2) % 8], 0);
            else            tick(0, 0, $urandom_range(0, 7), 0);
        end
        check("midseq_locked", int'(locked), 1);

        // Reset while locked with five errors recorded.
        do_reset();
        clean(4);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, wrong_code(), 0);
            clean(1);
        end
        check("err_cnt_five", int'(err_cnt), 5);
        tick(1, 1, good_code(), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_exp_code", int'(exp_code), 0);

        // Saturation: 2^W + 3 isolated locked errors.
        clean(4);
        for (int i = 0; i < ERR_MAX + 4; i++) begin
            tick(0, 1, wrong_code(), 0);
            clean(1);
        end
        check("err_saturated", int'(err_cnt), ERR_MAX);

`ifdef IND_CHK_ERR_CLR_EN
        // Clear together with a locked mismatch leaves one error counted.
        tick(0, 1, wrong_code(), 1);
        check("clr_with_err", int'(err_cnt), 1);
        tick(0, 1, good_code(), 1);
        check("clr_alone", int'(err_cnt), 0);
        check("clr_keeps_lock", int'(locked), 1);
`endif

        // Randomized traffic: mostly clean, with random gaps, errors and clears.
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit clr;
            int c;
            v   = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 9) < 8) ? good_code() : wrong_code();
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 999) == 0) tick(1, v, c, clr);
            else                             tick(0, v, c, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
